// File: rtl/cmat_mul_stream.sv
// NxN complex fixed-point matrix multiplier (C = A x B). Operands are loaded by address,
// products are accumulated one complex MAC per cycle, and C is streamed out as re/im words.
module cmat_mul_stream #(
  parameter int unsigned N    = 2,
  parameter int unsigned W    = 19,
  parameter int unsigned FRAC = 17,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_operand,
  input  logic [IW-1:0] in_row,
  input  logic [IW-1:0] in_col,
  input  logic          in_imag,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_imag,
  output logic          out_last,
  output logic          busy,
  output logic          sat
);

  localparam int unsigned PW = 2 * W + 1;
  localparam int unsigned AW = PW + IW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;

  localparam logic signed [AW-1:0] MAXV = AW'({1'b0, {(W-1){1'b1}}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  localparam logic signed [AW-1:0] RND  = AW'(1) << (FRAC - 1);
  localparam logic [IW-1:0]        LAST = IW'(N - 1);

  logic [1:0] state, state_next;

  logic signed [W-1:0] a_re [N][N];
  logic signed [W-1:0] a_im [N][N];
  logic signed [W-1:0] b_re [N][N];
  logic signed [W-1:0] b_im [N][N];
  logic signed [W-1:0] c_re [N][N];
  logic signed [W-1:0] c_im [N][N];

  logic [IW-1:0] ci, cj, ck, sr, sc;
  logic          si;

  logic signed [PW-1:0] ar, ai, br, bi, prod_re, prod_im;
  logic signed [AW-1:0] acc_re, acc_im, sum_re, sum_im, rnd_re, rnd_im;
  logic [W:0]           cl_re, cl_im;
  logic                 start_acc, mac_last, last_hs, load_word;

  // Clamp a rounded accumulator to W bits; MSB of the result flags a clamp.
  function automatic logic [W:0] clamp(input logic signed [AW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (v < MINV) return {1'b1, MINV[W-1:0]};
    else               return {1'b0, v[W-1:0]};
  endfunction

  // Complex product, accumulate, round half up and saturate for the current (i,j,k).
  always_comb begin
    ar      = PW'(a_re[ci][ck]);
    ai      = PW'(a_im[ci][ck]);
    br      = PW'(b_re[ck][cj]);
    bi      = PW'(b_im[ck][cj]);
    prod_re = ar * br - ai * bi;
    prod_im = ar * bi + ai * br;
    sum_re  = ((ck == '0) ? '0 : acc_re) + AW'(prod_re);
    sum_im  = ((ck == '0) ? '0 : acc_im) + AW'(prod_im);
    rnd_re  = (sum_re + RND) >>> FRAC;
    rnd_im  = (sum_im + RND) >>> FRAC;
    cl_re   = clamp(rnd_re);
    cl_im   = clamp(rnd_im);
  end

  // Control strobes shared by the FSM and the datapath.
  always_comb begin
    start_acc = (state == S_IDLE) && start;
    mac_last  = (state == S_COMPUTE) && (ci == LAST) && (cj == LAST) && (ck == LAST);
    last_hs   = (state == S_STREAM) && out_valid && out_ready && out_last;
    load_word = (state == S_STREAM) && (!out_valid || (out_ready && !out_last));
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_acc) state_next = S_COMPUTE;
      S_COMPUTE: if (mac_last)  state_next = S_STREAM;
      S_STREAM:  if (last_hs)   state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register with registered ready/busy flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_IDLE);
      busy     <= (state_next != S_IDLE);
    end
  end

  // Operand storage: written only while idle, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          a_re[r][c] <= '0;
          a_im[r][c] <= '0;
          b_re[r][c] <= '0;
          b_im[r][c] <= '0;
        end
      end
    end else if (state == S_IDLE && in_valid) begin
      case ({in_operand, in_imag})
        2'b00:   a_re[in_row][in_col] <= in_data;
        2'b01:   a_im[in_row][in_col] <= in_data;
        2'b10:   b_re[in_row][in_col] <= in_data;
        default: b_im[in_row][in_col] <= in_data;
      endcase
    end
  end

  // MAC sequencing (k fastest, then j, then i) and result/saturation capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      acc_re <= '0;
      acc_im <= '0;
      sat    <= 1'b0;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          c_re[r][c] <= '0;
          c_im[r][c] <= '0;
        end
      end
    end else if (start_acc) begin
      ci  <= '0;
      cj  <= '0;
      ck  <= '0;
      sat <= 1'b0;
    end else if (state == S_COMPUTE) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
      if (ck == LAST) begin
        c_re[ci][cj] <= cl_re[W-1:0];
        c_im[ci][cj] <= cl_im[W-1:0];
        sat          <= sat | cl_re[W] | cl_im[W];
        ck           <= '0;
        if (cj == LAST) begin
          cj <= '0;
          ci <= (ci == LAST) ? '0 : ci + 1'b1;
        end else begin
          cj <= cj + 1'b1;
        end
      end else begin
        ck <= ck + 1'b1;
      end
    end
  end

  // Result streaming: load the next word when the slot is empty or just consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_imag  <= 1'b0;
      out_last  <= 1'b0;
      sr        <= '0;
      sc        <= '0;
      si        <= 1'b0;
    end else if (start_acc) begin
      sr <= '0;
      sc <= '0;
      si <= 1'b0;
    end else if (load_word) begin
      out_valid <= 1'b1;
      out_data  <= si ? c_im[sr][sc] : c_re[sr][sc];
      out_row   <= sr;
      out_col   <= sc;
      out_imag  <= si;
      out_last  <= (sr == LAST) && (sc == LAST) && si;
      si        <= ~si;
      if (si) begin
        if (sc == LAST) begin
          sc <= '0;
          sr <= (sr == LAST) ? '0 : sr + 1'b1;
        end else begin
          sc <= sc + 1'b1;
        end
      end
    end else if (last_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmat_mul_stream.sv
// Directed bench for cmat_mul_stream at N=2, W=19, FRAC=17.
module tb_cmat_mul_stream;

  localparam int unsigned N    = 2;
  localparam int unsigned W    = 19;
  localparam int unsigned FRAC = 17;
  localparam int unsigned IW   = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_operand;
  logic [IW-1:0] in_row;
  logic [IW-1:0] in_col;
  logic          in_imag;
  logic          start;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_imag;
  logic          out_last;
  logic          busy;
  logic          sat;

  int vectors     = 0;
  int miscompares = 0;
  int got_re[4];
  int got_im[4];
  int first_lat;

  int zero4[4]  = '{0, 0, 0, 0};
  int ident[4]  = '{131072, 0, 0, 131072};
  int b1_re[4]  = '{1000, 2000, 3000, 4000};
  int b1_im[4]  = '{-5000, 6000, 7000, -8000};
  int imag_d[4] = '{131072, 0, 0, 131072};
  int negi[4]   = '{-131072, 0, 0, -131072};
  int had[4]    = '{92682, 92682, 92682, -92682};
  int had_p[4]  = '{92682, 92682, 92682, 0};
  int onep5[4]  = '{196608, 196608, 196608, 196608};
  int satv[4]   = '{262143, 262143, 262143, 262143};

  always #5 clk = ~clk;

  cmat_mul_stream #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_operand(in_operand), .in_row(in_row), .in_col(in_col), .in_imag(in_imag),
    .start(start), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_imag(out_imag), .out_last(out_last),
    .busy(busy), .sat(sat)
  );

  task automatic write_elem(input bit op, input int idx, input bit im, input int val, input bit with_start);
    @(negedge clk);
    in_valid   = 1'b1;
    in_operand = op;
    in_row     = 1'(idx / 2);
    in_col     = 1'(idx % 2);
    in_imag    = im;
    in_data    = 19'(val);
    start      = with_start;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic load_op(input bit op, input int re[4], input int im[4]);
    for (int i = 0; i < 4; i++) begin
      write_elem(op, i, 1'b0, re[i], 1'b0);
      write_elem(op, i, 1'b1, im[i], 1'b0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Gathers the 8 result words after a start-accept edge; checks order, last flag and stall hold.
  task automatic collect(input bit bp, input bit poke);
    int cyc;
    int n;
    bit pv, pr;
    logic [W-1:0]  hd;
    logic [IW-1:0] hr, hc;
    logic          hi, hl;
    cyc = 0; n = 0; first_lat = -1; pv = 0; pr = 0;
    hd = '0; hr = '0; hc = '0; hi = 0; hl = 0;
    while (n < 8 && cyc < 300) begin
      @(negedge clk);
      if (pv && !pr) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== hd || out_row !== hr || out_col !== hc ||
            out_imag !== hi || out_last !== hl) begin
          miscompares++;
          $display("FAIL hold_stable word %0d: got v=%0b d=%0d, required v=1 d=%0d", n, out_valid, out_data, hd);
        end
      end
      if (out_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (!bp)           out_ready = 1'b1;
      else if (cyc < 24) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else               out_ready = 1'($urandom_range(0, 1));
      if (poke && n < 6) begin
        in_valid   = 1'b1;
        in_operand = 1'($urandom_range(0, 1));
        in_row     = 1'($urandom_range(0, 1));
        in_col     = 1'($urandom_range(0, 1));
        in_imag    = 1'($urandom_range(0, 1));
        in_data    = 19'($urandom);
        start      = 1'b1;
      end else begin
        in_valid = 1'b0;
        start    = 1'b0;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (out_row !== 1'(n / 4) || out_col !== 1'((n / 2) % 2) || out_imag !== 1'(n % 2) ||
            out_last !== (n == 7)) begin
          miscompares++;
          $display("FAIL word_order word %0d: got r=%0d c=%0d i=%0b l=%0b, required r=%0d c=%0d i=%0d l=%0b",
                   n, out_row, out_col, out_imag, out_last, n / 4, (n / 2) % 2, n % 2, (n == 7));
        end
        if (n % 2 == 1) got_im[n / 2] = int'($signed(out_data));
        else            got_re[n / 2] = int'($signed(out_data));
        n++;
      end
      pv = out_valid; pr = out_ready;
      hd = out_data; hr = out_row; hc = out_col; hi = out_imag; hl = out_last;
      cyc++;
    end
    vectors++;
    if (n < 8) begin
      miscompares++;
      $display("FAIL stream_timeout: got %0d words, required 8", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL end_state: got v=%0b busy=%0b rdy=%0b, required 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; in_data = '0; in_operand = 0; in_row = '0; in_col = '0;
    in_imag = 0; start = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sat !== 1'b0 ||
        out_data !== '0 || out_last !== 1'b0 || out_row !== '0 || out_col !== '0 || out_imag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%0b v=%0b busy=%0b sat=%0b d=%0d, required 1 0 0 0 0",
               in_ready, out_valid, busy, sat, out_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_identity();
    load_op(1'b0, ident, zero4);
    load_op(1'b1, b1_re, b1_im);
    pulse_start();
    collect(1'b0, 1'b0);
    vectors++;
    if (first_lat !== 9) begin
      miscompares++;
      $display("FAIL identity_latency: got %0d, required 9", first_lat);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== b1_re[i] || got_im[i] !== b1_im[i]) begin
        miscompares++;
        $display("FAIL identity_elem %0d: got %0d/%0d, required %0d/%0d", i, got_re[i], got_im[i], b1_re[i], b1_im[i]);
      end
    end
    vectors++;
    if (sat !== 1'b0) begin
      miscompares++;
      $display("FAIL identity_sat: got %0b, required 0", sat);
    end
  endtask

  task automatic test_imaginary();
    load_op(1'b0, zero4, imag_d);
    load_op(1'b1, zero4, imag_d);
    pulse_start();
    collect(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== negi[i] || got_im[i] !== 0) begin
        miscompares++;
        $display("FAIL imag_elem %0d: got %0d/%0d, required %0d/0", i, got_re[i], got_im[i], negi[i]);
      end
    end
    vectors++;
    if (sat !== 1'b0) begin
      miscompares++;
      $display("FAIL imag_sat: got %0b, required 0", sat);
    end
  endtask

  // Last B element is written in the same cycle as start; the multiply must see it.
  task automatic test_hadamard();
    load_op(1'b0, had, zero4);
    load_op(1'b1, had_p, zero4);
    write_elem(1'b1, 3, 1'b0, -92682, 1'b1);
    collect(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== ident[i] || got_im[i] !== 0) begin
        miscompares++;
        $display("FAIL hadamard_elem %0d: got %0d/%0d, required %0d/0", i, got_re[i], got_im[i], ident[i]);
      end
    end
  endtask

  task automatic test_saturation();
    load_op(1'b0, onep5, zero4);
    load_op(1'b1, onep5, zero4);
    pulse_start();
    collect(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== satv[i] || got_im[i] !== 0) begin
        miscompares++;
        $display("FAIL sat_elem %0d: got %0d/%0d, required %0d/0", i, got_re[i], got_im[i], satv[i]);
      end
    end
    vectors++;
    if (sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_flag: got %0b, required 1", sat);
    end
  endtask

  task automatic test_backpressure();
    load_op(1'b0, ident, zero4);
    load_op(1'b1, b1_re, b1_im);
    pulse_start();
    vectors++;
    if (sat !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_accept: got sat=%0b busy=%0b rdy=%0b, required 0 1 0", sat, busy, in_ready);
    end
    collect(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== b1_re[i] || got_im[i] !== b1_im[i]) begin
        miscompares++;
        $display("FAIL bp_elem %0d: got %0d/%0d, required %0d/%0d", i, got_re[i], got_im[i], b1_re[i], b1_im[i]);
      end
    end
    out_ready = 1'b1;
    pulse_start();
    collect(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== b1_re[i] || got_im[i] !== b1_im[i]) begin
        miscompares++;
        $display("FAIL operands_held %0d: got %0d/%0d, required %0d/%0d", i, got_re[i], got_im[i], b1_re[i], b1_im[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%0b busy=%0b rdy=%0b sat=%0b, required 0 0 1 0", out_valid, busy, in_ready, sat);
    end
    pulse_start();
    collect(1'b0, 1'b0);
    vectors++;
    if (first_lat !== 9) begin
      miscompares++;
      $display("FAIL reset_mid_latency: got %0d, required 9", first_lat);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_re[i] !== 0 || got_im[i] !== 0) begin
        miscompares++;
        $display("FAIL reset_mid_elem %0d: got %0d/%0d, required 0/0", i, got_re[i], got_im[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_imaginary();
    test_hadamard();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
